sirv_pwm_gen: RTL
=================

# sirv_pwm_gen

Parametrised multi-channel PWM peripheral with a native ICB slave port. It replaces the fixed 4-channel, 8-bit wrapper-plus-converter arrangement. Channel count and comparator width are configurable, and it adds a center-aligned counting mode and write-1-to-clear interrupt pending bits. It sits on the peripheral ICB fabric; the base address is decoded upstream and only `i_icb_cmd_addr[7:2]` is used.

## Interface
- `NCH`, default 4: number of PWM channels, 1..8.
- `CW`, default 8: comparator/scaled-count width, 8..16.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_icb_cmd_valid` in 1: command valid.
- `i_icb_cmd_ready` out 1: command accepted when high with valid.
- `i_icb_cmd_addr` in 32: byte address; bits [7:2] decoded.
- `i_icb_cmd_read` in 1: 1 = read, 0 = write.
- `i_icb_cmd_wdata` in 32: write data; full-word writes only.
- `i_icb_rsp_valid` out 1: response valid.
- `i_icb_rsp_ready` in 1: response accepted.
- `i_icb_rsp_rdata` out 32: read data; 0 for writes and unmapped reads.
- `io_interrupts` out NCH: per-channel pending bit ip[i].
- `io_gpio` out NCH: per-channel PWM output.

## Operation
- Register map (word offsets):
  - 0x00 CFG: [3:0] scale, [8] zerocmp, [9] center, [12] enalways, [13] enoneshot, [16+i] ip[i] (write 1 clears; reads the pending bit).
  - 0x08 COUNT: R/W, CW+15 bits.
  - 0x10 SCALED: RO, `s = COUNT[scale +: CW]`.
  - 0x20+4i CMPi: R/W, CW bits.
- Unmapped offsets and CMPi with i ≥ NCH: read 0, writes ignored, response still returned.
- Counter enable: `en = enalways | enoneshot`.
- Edge mode (center=0), when en:
  - COUNT += 1, modulo 2^(CW+15).
  - Wrap event: COUNT is all-ones, or zerocmp=1 and s == CMP0 with the COUNT low `scale` bits all ones.
  - On wrap, COUNT ← 0.
- Center mode (center=1), when en:
  - Internal direction bit `dn` (reset 0).
  - Up: COUNT += 1 until s == CMP0 with the low `scale` bits all ones; then `dn` ← 1.
  - Down: COUNT −= 1 until COUNT == 0; then `dn` ← 0 and a wrap event fires.
  - CMP0 == 0 holds COUNT at 0 and fires a wrap event every enabled cycle.
- On a wrap event, enoneshot is cleared by hardware.
- Outputs: `cmp_hit[i] = (s >= CMPi)`; `io_gpio[i]` is the registered `cmp_hit[i]`.
- ip[i] is set on a rising edge of `io_gpio[i]` and stays set until software writes 1 to it.

## Timing
- Reset values:
  - `io_gpio` = 0, `io_interrupts` = 0, `i_icb_rsp_valid` = 0, `i_icb_rsp_rdata` = 0, `i_icb_cmd_ready` = 1.
  - All registers 0; `dn` = 0.
- Handshake:
  - `cmd_ready = ~rsp_valid | rsp_ready`.
  - Accepted command produces `rsp_valid` the next cycle, with rdata registered.
  - rsp holds stable until `rsp_ready`.
  - Back-to-back commands are sustained at 1 per cycle while `rsp_ready` = 1.
- A write takes effect on the cycle after acceptance. A read returns the register value at the acceptance edge.
- `io_gpio` lags COUNT by one cycle. ip sets the cycle after the `io_gpio` rising edge.
- Simultaneous events:
  - COUNT write vs increment/wrap: write wins.
  - CFG write setting enoneshot vs hardware clear: write wins.
  - ip W1C vs hardware set in the same cycle: set wins.
- Writing `center` resets `dn` to 0.
- Reset mid-transaction drops any pending response; no response is issued after reset.

## Test plan
- **Reset/read-back:** after reset, read CFG, COUNT and CMP0..NCH-1 → all 0, `io_gpio` = 0, `io_interrupts` = 0. Write CMP1 = 0x5A → read returns 0x5A.
- **Edge PWM:** NCH=4, CW=8. Set CMP0 = 9, CMP1 = 5, scale = 0, zerocmp = 1, enalways = 1.
  - Expect period 10 cycles.
  - `io_gpio[1]` high for 5 of every 10 cycles, rising 1 cycle after s = 5.
  - ip[1] sets once.
- **Center mode:** CMP0 = 4, CMP2 = 2, center = 1. Expect s sequence 0,1,2,3,4,3,2,1,0,1…; `io_gpio[2]` high while s ≥ 2 (5 of every 8 cycles).
- **One-shot with scale:** scale = 2, CMP0 = 3, zerocmp = 1, enoneshot = 1.
  - COUNT runs 0..15 and wraps to 0.
  - enoneshot reads 0 afterwards; COUNT stays at 0.
- **Interrupt race:** write 1 to ip[0] in the same cycle `io_gpio[0]` rises → ip[0] remains 1. Then write 1 again → 0.
- **Backpressure:** hold `rsp_ready` = 0 with a read pending.
  - `cmd_ready` = 0 and rdata is stable.
  - Release → next command accepted the same cycle.
  - A read of an unmapped offset (0x7C) returns 0.

Source files
------------

// File: rtl/sirv_pwm_gen_if.sv
// ICB command/response bundle for the PWM generator slave port.
// Master drives command and response-ready; slave returns ready, valid and read data.
interface sirv_pwm_gen_if;
   logic        i_icb_cmd_valid;
   logic        i_icb_cmd_ready;
   logic [31:0] i_icb_cmd_addr;
   logic        i_icb_cmd_read;
   logic [31:0] i_icb_cmd_wdata;
   logic        i_icb_rsp_valid;
   logic        i_icb_rsp_ready;
   logic [31:0] i_icb_rsp_rdata;

   modport master (
      output i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_rsp_ready,
      input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
   );

   modport slave (
      input  i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_rsp_ready,
      output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_rdata
   );
endinterface

// File: rtl/sirv_pwm_gen.sv
// Multi-channel PWM peripheral: scalable counter with edge or center-aligned counting,
// per-channel comparators, registered PWM outputs and sticky rising-edge interrupt bits.
module sirv_pwm_gen #(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   sirv_pwm_gen_if.slave    icb,
   output logic [NCH-1:0]   io_interrupts,
   output logic [NCH-1:0]   io_gpio
);

   localparam int CNTW = CW + 15;
   localparam logic [5:0] OFF_CFG    = 6'h00;
   localparam logic [5:0] OFF_COUNT  = 6'h02;
   localparam logic [5:0] OFF_SCALED = 6'h04;
   localparam logic [5:0] OFF_CMP0   = 6'h08;

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   logic [3:0]      scale;
   logic            zerocmp;
   logic            center;
   logic            enalways;
   logic            enoneshot;
   logic [NCH-1:0]  ip;
   logic [CNTW-1:0] count;
   logic [CNTW-1:0] count_nxt;
   dir_t            dir;
   dir_t            dir_nxt;
   logic [CW-1:0]   cmp [NCH];
   logic [NCH-1:0]  gpio_q;
   logic [NCH-1:0]  gpio_d;
   logic [NCH-1:0]  cmp_hit;

   logic            rsp_valid;
   logic [31:0]     rsp_rdata;
   logic [31:0]     rd_data;
   logic            cmd_ready;
   logic            cmd_fire;
   logic            wr_fire;
   logic            cfg_wr;
   logic            count_wr;
   logic [5:0]      offset;

   logic [CNTW-1:0] shifted;
   logic [CNTW-1:0] low_mask;
   logic [CW-1:0]   s;
   logic            top_hit;
   logic            wrap;
   logic            en;
   logic            unused_bits;

   assign offset      = icb.i_icb_cmd_addr[7:2];
   assign cmd_ready   = ~rsp_valid | icb.i_icb_rsp_ready;
   assign cmd_fire    = icb.i_icb_cmd_valid & cmd_ready;
   assign wr_fire     = cmd_fire & ~icb.i_icb_cmd_read;
   assign cfg_wr      = wr_fire & (offset == OFF_CFG);
   assign count_wr    = wr_fire & (offset == OFF_COUNT);
   assign unused_bits = ^{icb.i_icb_cmd_addr[31:8], icb.i_icb_cmd_addr[1:0], icb.i_icb_cmd_wdata};

   assign icb.i_icb_cmd_ready = cmd_ready;
   assign icb.i_icb_rsp_valid = rsp_valid;
   assign icb.i_icb_rsp_rdata = rsp_rdata;
   assign io_gpio             = gpio_q;
   assign io_interrupts       = ip;

   // The period end is matched only once the bits below the scaled window are all ones,
   // so a full scaled step elapses before the wrap or turn-around.
   assign shifted  = count >> scale;
   assign s        = shifted[CW-1:0];
   assign low_mask = ~({CNTW{1'b1}} << scale);
   assign top_hit  = (s == cmp[0]) && ((count & low_mask) == low_mask);
   assign en       = enalways | enoneshot;

   always_comb begin
      count_nxt = count;
      dir_nxt   = dir;
      wrap      = 1'b0;
      if (en) begin
         if (!center) begin
            wrap      = (&count) | (zerocmp & top_hit);
            count_nxt = wrap ? '0 : count + CNTW'(1);
         end else if (cmp[0] == '0) begin
            count_nxt = '0;
            wrap      = 1'b1;
         end else if (dir == DIR_UP) begin
            if (top_hit) begin
               dir_nxt   = DIR_DOWN;
               count_nxt = count - CNTW'(1);
            end else begin
               count_nxt = count + CNTW'(1);
            end
         end else if (count == '0) begin
            dir_nxt   = DIR_UP;
            wrap      = 1'b1;
            count_nxt = count + CNTW'(1);
         end else begin
            count_nxt = count - CNTW'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         cmp_hit[i] = (s >= cmp[i]);
      end
   end

   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_CFG: begin
            rd_data[3:0]       = scale;
            rd_data[8]         = zerocmp;
            rd_data[9]         = center;
            rd_data[12]        = enalways;
            rd_data[13]        = enoneshot;
            rd_data[16 +: NCH] = ip;
         end
         OFF_COUNT:  rd_data[CNTW-1:0] = count;
         OFF_SCALED: rd_data[CW-1:0]   = s;
         default: begin
            for (int i = 0; i < NCH; i++) begin
               if (offset == OFF_CMP0 + 6'(i)) rd_data[CW-1:0] = cmp[i];
            end
         end
      endcase
   end

   // Software writes take priority over the hardware's own counter and one-shot updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scale     <= '0;
         zerocmp   <= 1'b0;
         center    <= 1'b0;
         enalways  <= 1'b0;
         enoneshot <= 1'b0;
         count     <= '0;
         dir       <= DIR_UP;
      end else begin
         if (cfg_wr) begin
            scale     <= icb.i_icb_cmd_wdata[3:0];
            zerocmp   <= icb.i_icb_cmd_wdata[8];
            center    <= icb.i_icb_cmd_wdata[9];
            enalways  <= icb.i_icb_cmd_wdata[12];
            enoneshot <= icb.i_icb_cmd_wdata[13];
            dir       <= DIR_UP;
         end else begin
            if (wrap) enoneshot <= 1'b0;
            dir <= dir_nxt;
         end
         count <= count_wr ? icb.i_icb_cmd_wdata[CNTW-1:0] : count_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) cmp[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (wr_fire && (offset == OFF_CMP0 + 6'(i))) cmp[i] <= icb.i_icb_cmd_wdata[CW-1:0];
         end
      end
   end

   // A hardware set in the same cycle as a write-1-to-clear keeps the pending bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_q <= '0;
         gpio_d <= '0;
         ip     <= '0;
      end else begin
         gpio_q <= cmp_hit;
         gpio_d <= gpio_q;
         ip     <= (ip & ~(cfg_wr ? icb.i_icb_cmd_wdata[16 +: NCH] : {NCH{1'b0}}))
                   | (gpio_q & ~gpio_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else if (cmd_fire) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= icb.i_icb_cmd_read ? rd_data : 32'h0;
      end else if (icb.i_icb_rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
